// File: rtl/data_mem_controller.sv
// Multi-cycle data-memory controller: 32-bit word accesses as two big-endian halfword phases on a 16-bit SRAM port.
// Latency: 2*WAIT_CYCLES+3 cycles in range, 1 cycle out of range; ready held low while an access is in flight.
module data_mem_controller #(
    parameter int ADDRESS_LEN = 32,
    parameter int MEM_BASE    = 1024,
    parameter int MEM_SIZE    = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [ADDRESS_LEN-1:0] address,
    input  logic [ADDRESS_LEN-1:0] write_data,
    output logic [ADDRESS_LEN-1:0] read_data,
    output logic                   ready,
    output logic                   range_err,
    output logic [ADDRESS_LEN-1:0] sram_addr,
    output logic [15:0]            sram_wdata,
    input  logic [15:0]            sram_rdata,
    output logic                   sram_we,
    output logic                   sram_oe
);

    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

    localparam logic [ADDRESS_LEN-1:0] BASE      = ADDRESS_LEN'(MEM_BASE);
    localparam logic [ADDRESS_LEN-1:0] LIMIT     = ADDRESS_LEN'(MEM_BASE + MEM_SIZE);
    localparam logic [3:0]             WAIT_LAST = 4'(WAIT_CYCLES);

    state_t                   state, state_nxt;
    logic                     request;
    logic                     in_range;
    logic                     phase_last;
    logic [ADDRESS_LEN-1:0]   aligned;
    logic [ADDRESS_LEN-1:0]   offset;
    logic [ADDRESS_LEN-1:0]   offset_q;
    logic [15:0]              wdata_lo_q;
    logic                     store_q;
    logic [3:0]               wait_cnt;
    logic                     unused_byte_sel;

    assign request         = mem_r_en | mem_w_en;
    assign aligned         = {address[ADDRESS_LEN-1:2], 2'b00};
    assign offset          = aligned - BASE;
    assign in_range        = (aligned >= BASE) && (aligned < LIMIT);
    assign phase_last      = (wait_cnt == WAIT_LAST);
    assign unused_byte_sel = ^address[1:0];

    assign ready = ~rst & (((state == IDLE) & ~request) | (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (request) state_nxt = in_range ? HI : DONE;
            HI:      if (phase_last) state_nxt = LO;
            LO:      if (phase_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM address/data/strobes are registered so they stay stable for the whole phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data  <= '0;
            range_err  <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            sram_oe    <= 1'b0;
            offset_q   <= '0;
            wdata_lo_q <= '0;
            store_q    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            range_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        if (in_range) begin
                            offset_q   <= offset;
                            store_q    <= mem_w_en;
                            wdata_lo_q <= write_data[15:0];
                            wait_cnt   <= '0;
                            sram_addr  <= offset;
                            sram_wdata <= write_data[ADDRESS_LEN-1 -: 16];
                            sram_we    <= mem_w_en;
                            sram_oe    <= ~mem_w_en;
                        end else begin
                            range_err <= 1'b1;
                            read_data <= '0;
                        end
                    end
                end
                HI: begin
                    if (phase_last) begin
                        if (!store_q) read_data[ADDRESS_LEN-1 -: 16] <= sram_rdata;
                        wait_cnt   <= '0;
                        sram_addr  <= offset_q + ADDRESS_LEN'(2);
                        sram_wdata <= wdata_lo_q;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                LO: begin
                    if (phase_last) begin
                        if (!store_q) read_data[15:0] <= sram_rdata;
                        wait_cnt <= '0;
                        sram_we  <= 1'b0;
                        sram_oe  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
